serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_full_adder.sv | 18 +
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial arithmetic blocks.
// Holds the common three-state sequencing encoding used by every
// bit-serial unit (adder, and later subtractor/comparator siblings).
package serial_adder_pkg;

  // Sequencer states shared by the serial arithmetic family.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } serial_state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used by the serial adder.
// Ports:
//   a, b  : operand bits
//   c     : carry in
//   sum   : a ^ b ^ c
//   carry : majority(a, b, c)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// A start in IDLE captures the operands, WIDTH SHIFT cycles run them through
// a single full-adder cell, and a one-cycle DONE state publishes the result.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : begin an addition (only honoured in IDLE)
//   a, b, cin  : operands and carry-in, captured on the accepted start edge
//   sum, cout  : registered result, held until the next completion
//   busy       : high while in SHIFT
//   done       : one-cycle pulse when a new result is presented
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  // Wide enough to hold WIDTH itself, so the counter never wraps mid-operation.
  localparam int CNT_W = $clog2(WIDTH + 1);

  serial_state_t    state;
  serial_state_t    state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  full_adder u_full_adder (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at bit 0.
  assign psum_next = {fa_sum, psum[WIDTH-1:1]};
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: default assignment first so no path leaves state_next unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_SHIFT;
      S_SHIFT: if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode: busy and done are pure state decodes, so never both high.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath. The result registers are only written on the final shift edge,
  // so they hold through DONE, IDLE and the whole of the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        S_SHIFT: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          psum  <= psum_next;
          carry <= fa_carry;
          cnt   <= cnt + CNT_W'(1);
          // Publish on the same edge as the last bit, straight from the adder.
          if (last_bit) begin
            sum  <= psum_next;
            cout <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a WIDTH=8 instance for directed
// vectors, latency, start-hold and reset-abort cases, and a WIDTH=4
// instance swept over every (a, b, cin) combination.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] sum8;
  logic       cout8, busy8, done8;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic [3:0] sum4;
  logic       cout4, busy4, done4;

  int n_checks;
  int n_bad;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .sum   (sum8),
    .cout  (cout8),
    .busy  (busy8),
    .done  (done8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .sum   (sum4),
    .cout  (cout4),
    .busy  (busy4),
    .done  (done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 addition with hand-computed expected result. Operands are
  // scrambled right after the accept edge; the result must not notice.
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic tc, input logic [7:0] exp_sum, input logic exp_cout);
    int lat;
    int busy_n;
    int both_n;
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = ~ta; b8 = 8'h5A; cin8 = ~tc;
    lat = 0; busy_n = 0; both_n = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy8 === 1'b1) busy_n++;
      if (busy8 === 1'b1 && done8 === 1'b1) both_n++;
    end
    check({tag, " latency"}, lat, 9);
    check({tag, " busy_cycles"}, busy_n, 8);
    check({tag, " busy_and_done"}, both_n, 0);
    check({tag, " sum"}, sum8, exp_sum);
    check({tag, " cout"}, cout8, exp_cout);
    @(negedge clk);
    check({tag, " done_single"}, done8, 0);
    check({tag, " sum_hold"}, sum8, exp_sum);
  endtask

  initial begin
    logic [8:0] exp9;
    logic [8:0] held_exp [0:2];
    logic [4:0] prev5;
    logic [4:0] exp5;
    int         ndone;
    int         lat;

    n_checks = 0;
    n_bad    = 0;
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst sum", sum8, 0);
    check("rst cout", cout8, 0);
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);

    // Release mid-high-phase: the very next rising edge must accept start.
    #1 rst_n = 1'b1;

    op8("0f+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    op8("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    op8("a5+5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);
    op8("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    op8("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

    // start held high with operands changing every cycle; only edges
    // 0, 10 and 20 accept. Expected: 0x0B+0x05+1, 0x7D+0x93+0, 0xEF+0x21+1.
    held_exp[0] = 9'h011;
    held_exp[1] = 9'h110;
    held_exp[2] = 9'h111;
    ndone = 0;
    @(negedge clk);
    start8 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a8   = 8'(i * 37 + 11);
      b8   = 8'(i * 91 + 5);
      cin8 = (i % 4 == 0);
      @(posedge clk);
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
      if (i % 10 == 8) begin
        check("held done", done8, 1);
        check("held result", {cout8, sum8}, held_exp[i / 10]);
      end
    end
    start8 = 1'b0;
    check("held done_count", ndone, 3);

    // Reset four cycles into an operation: outputs clear at once, no done.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort sum", sum8, 0);
    check("abort cout", cout8, 0);
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    ndone = 0;
    repeat (2) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) ndone++;
    end
    check("abort no_done", ndone, 0);
    op8("05+03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);

    // WIDTH=4 sweep: every (a, b, cin); previous result must hold while running.
    prev5 = '0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      a4 = 4'(k >> 5); b4 = 4'(k >> 1); cin4 = k[0]; start4 = 1'b1;
      exp5 = 5'(a4) + 5'(b4) + 5'(cin4);
      @(posedge clk);
      #1 start4 = 1'b0;
      check("w4 hold", {cout4, sum4}, prev5);
      lat = 0;
      while (done4 !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("w4 latency", lat, 5);
      check("w4 result", {cout4, sum4}, exp5);
      prev5 = exp5;
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule : tb_serial_adder
